uart_rx_byte: RTL and testbench



---
 rtl/uart_rx_byte.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_byte.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: synchronises Rx, deserialises LSB-first frames and
// presents each good byte on Data with a DoneSig pulse of DONE_CYCLES clocks.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DONE_CYCLES  = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    output logic [7:0] Data,
    output logic       DoneSig,
    output logic       RxBusy,
    output logic       FrameErr
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [DW-1:0] DONE_LAST = DW'(DONE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4,
        BREAK = 3'd5
    } stateT;

    logic          rxMeta;
    logic          rxS;
    stateT         state;
    stateT         stateNext;
    logic [CW-1:0] bitCnt;
    logic [CW-1:0] bitCntNext;
    logic [2:0]    bitIdx;
    logic [2:0]    bitIdxNext;
    logic [7:0]    shiftReg;
    logic [7:0]    shiftNext;
    logic [DW-1:0] doneCnt;
    logic [DW-1:0] doneCntNext;
    logic [7:0]    dataNext;
    logic          doneNext;
    logic          busyNext;
    logic          ferrNext;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= Rx;
            rxS    <= rxMeta;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            doneCnt  <= '0;
            Data     <= 8'h00;
            DoneSig  <= 1'b0;
            RxBusy   <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            state    <= stateNext;
            bitCnt   <= bitCntNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftNext;
            doneCnt  <= doneCntNext;
            Data     <= dataNext;
            DoneSig  <= doneNext;
            RxBusy   <= busyNext;
            FrameErr <= ferrNext;
        end
    end

    always_comb begin
        stateNext   = state;
        bitCntNext  = bitCnt;
        bitIdxNext  = bitIdx;
        shiftNext   = shiftReg;
        doneCntNext = doneCnt;
        dataNext    = Data;
        doneNext    = 1'b0;
        busyNext    = RxBusy;
        ferrNext    = 1'b0;

        case (state)
            IDLE: begin
                busyNext = 1'b0;
                if (!rxS) begin
                    stateNext  = START;
                    bitCntNext = '0;
                    busyNext   = 1'b1;
                end
            end
            // Re-check the line at mid start bit to reject glitches.
            START: begin
                if (bitCnt == HALF_LAST) begin
                    if (!rxS) begin
                        stateNext  = DATA;
                        bitCntNext = '0;
                        bitIdxNext = '0;
                    end else begin
                        stateNext = IDLE;
                        busyNext  = 1'b0;
                    end
                end else begin
                    bitCntNext = bitCnt + CW'(1);
                end
            end
            DATA: begin
                if (bitCnt == BIT_LAST) begin
                    bitCntNext        = '0;
                    shiftNext[bitIdx] = rxS;
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                    end
                end else begin
                    bitCntNext = bitCnt + CW'(1);
                end
            end
            STOP: begin
                if (bitCnt == BIT_LAST) begin
                    bitCntNext = '0;
                    if (rxS) begin
                        dataNext    = shiftReg;
                        doneNext    = 1'b1;
                        doneCntNext = '0;
                        stateNext   = DONE;
                    end else begin
                        ferrNext  = 1'b1;
                        stateNext = BREAK;
                    end
                end else begin
                    bitCntNext = bitCnt + CW'(1);
                end
            end
            // The assertion cycle counts as the first DoneSig cycle.
            DONE: begin
                if (doneCnt == DONE_LAST) begin
                    stateNext = IDLE;
                    busyNext  = 1'b0;
                end else begin
                    doneNext    = 1'b1;
                    doneCntNext = doneCnt + DW'(1);
                end
            end
            BREAK: begin
                if (rxS) begin
                    stateNext = IDLE;
                    busyNext  = 1'b0;
                end
            end
            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: one instance with 1-clock DoneSig and one
// with a 3-clock DoneSig, both at 16 clocks per bit.
module tb_uart_rx_byte;

    localparam int unsigned CPB = 16;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Rx;
    logic       Rx3;
    logic [7:0] Data;
    logic       DoneSig;
    logic       RxBusy;
    logic       FrameErr;
    logic [7:0] Data3;
    logic       DoneSig3;
    logic       RxBusy3;
    logic       FrameErr3;

    int checks   = 0;
    int failures = 0;

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .DONE_CYCLES(1)) dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Data(Data),
        .DoneSig(DoneSig), .RxBusy(RxBusy), .FrameErr(FrameErr)
    );

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .DONE_CYCLES(3)) dut3 (
        .Clk(Clk), .Rst(Rst), .Rx(Rx3), .Data(Data3),
        .DoneSig(DoneSig3), .RxBusy(RxBusy3), .FrameErr(FrameErr3)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge.
    logic       prevDone = 1'b0;
    logic       prevBusy = 1'b0;
    logic [7:0] prevData = 8'h00;
    int doneCount = 0, doneHigh = 0, ferrHigh = 0, busyRise = 0, badChange = 0;
    int doneRiseCyc = 0, doneFallCyc = 0, busyRiseCyc = 0, busyFallCyc = 0;
    logic [7:0] gotQ[$];
    logic       prevDone3 = 1'b0;
    int done3Count = 0, done3High = 0, ferr3High = 0;
    logic [7:0] data3Cap = 8'h00;

    always @(negedge Clk) begin
        prevData <= Data;
        if (Rst) begin
            prevDone  <= 1'b0;
            prevBusy  <= 1'b0;
            prevDone3 <= 1'b0;
        end else begin
            prevDone  <= DoneSig;
            prevBusy  <= RxBusy;
            prevDone3 <= DoneSig3;
            if (DoneSig && !prevDone) begin
                doneCount   <= doneCount + 1;
                doneRiseCyc <= cyc;
                gotQ.push_back(Data);
            end
            if (!DoneSig && prevDone) doneFallCyc <= cyc;
            if (DoneSig) doneHigh <= doneHigh + 1;
            if (FrameErr) ferrHigh <= ferrHigh + 1;
            if (RxBusy && !prevBusy) begin
                busyRise    <= busyRise + 1;
                busyRiseCyc <= cyc;
            end
            if (!RxBusy && prevBusy) busyFallCyc <= cyc;
            if ((Data !== prevData) && !(DoneSig && !prevDone)) badChange <= badChange + 1;
            if (DoneSig3 && !prevDone3) begin
                done3Count <= done3Count + 1;
                data3Cap   <= Data3;
            end
            if (DoneSig3) done3High <= done3High + 1;
            if (FrameErr3) ferr3High <= ferr3High + 1;
        end
    end

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)",
                   tag, observed, observed, expected, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Drives one frame on the selected line; must be called on a falling edge.
    // The line is left at the stop-bit level.
    task automatic sendFrame(input bit sel3, input logic [7:0] b, input logic stopBit);
        if (sel3) Rx3 = 1'b0; else Rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            if (sel3) Rx3 = b[i]; else Rx = b[i];
            idle(CPB);
        end
        if (sel3) Rx3 = stopBit; else Rx = stopBit;
        idle(CPB);
    endtask

    int  t0;
    bit  stable;
    logic [7:0] abortByte;

    initial begin
        Rst = 1'b1;
        Rx  = 1'b1;
        Rx3 = 1'b1;
        idle(3);
        #1;
        check("reset Data", Data, 8'h00);
        check("reset DoneSig", DoneSig, 0);
        check("reset RxBusy", RxBusy, 0);
        check("reset FrameErr", FrameErr, 0);
        @(negedge Clk);
        Rst = 1'b0;
        idle(20);

        // 1: single byte 0x47
        t0 = cyc;
        sendFrame(1'b0, 8'h47, 1'b1);
        idle(10);
        check("t1 doneCount", doneCount, 1);
        check("t1 Data captured", int'(gotQ[0]), 8'h47);
        check("t1 latency", doneRiseCyc - t0, 155);
        check("t1 busy rise", busyRiseCyc - t0, 3);
        check("t1 done width", doneHigh, 1);
        check("t1 busy falls with done", busyFallCyc, doneFallCyc);
        check("t1 no FrameErr", ferrHigh, 0);
        check("t1 Data held", Data, 8'h47);

        // 2: 5-clock glitch
        Rx = 1'b0;
        idle(5);
        Rx = 1'b1;
        idle(40);
        check("t2 busy pulsed", busyRise, 2);
        check("t2 RxBusy idle", RxBusy, 0);
        check("t2 no DoneSig", doneCount, 1);
        check("t2 no FrameErr", ferrHigh, 0);
        check("t2 Data kept", Data, 8'h47);

        // 3: bad stop bit followed by a long break
        sendFrame(1'b0, 8'hA5, 1'b0);
        idle(40 * CPB);
        check("t3 one FrameErr", ferrHigh, 1);
        check("t3 busy in break", RxBusy, 1);
        Rx = 1'b1;
        idle(2);
        check("t3 busy 2 clks after high", RxBusy, 1);
        idle(1);
        check("t3 busy dropped", RxBusy, 0);
        idle(20);
        check("t3 no DoneSig", doneCount, 1);
        check("t3 Data kept", Data, 8'h47);
        check("t3 FrameErr single", ferrHigh, 1);

        // 4: back-to-back frames
        sendFrame(1'b0, 8'h48, 1'b1);
        sendFrame(1'b0, 8'h69, 1'b1);
        sendFrame(1'b0, 8'hFF, 1'b1);
        sendFrame(1'b0, 8'hFF, 1'b1);
        idle(20);
        check("t4 doneCount", doneCount, 5);
        check("t4 byte0", int'(gotQ[1]), 8'h48);
        check("t4 byte1", int'(gotQ[2]), 8'h69);
        check("t4 byte2", int'(gotQ[3]), 8'hFF);
        check("t4 byte3", int'(gotQ[4]), 8'hFF);
        check("t4 done width", doneHigh, 5);
        check("t4 no FrameErr", ferrHigh, 1);
        check("t4 Data held", Data, 8'hFF);

        // 5: reset during data bit 4 of 0x52, then 0x72
        abortByte = 8'h52;
        Rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            Rx = abortByte[i];
            idle(CPB);
        end
        Rx = abortByte[4];
        idle(CPB / 2);
        Rst = 1'b1;
        #1;
        check("t5 reset Data", Data, 8'h00);
        check("t5 reset RxBusy", RxBusy, 0);
        check("t5 reset DoneSig", DoneSig, 0);
        check("t5 reset FrameErr", FrameErr, 0);
        Rx = 1'b1;
        idle(3);
        Rst = 1'b0;
        idle(20);
        check("t5 nothing after reset", doneCount, 5);
        sendFrame(1'b0, 8'h72, 1'b1);
        idle(20);
        check("t5 doneCount", doneCount, 6);
        check("t5 queue size", gotQ.size(), 6);
        check("t5 byte", int'(gotQ[5]), 8'h72);
        check("t5 Data", Data, 8'h72);
        check("Data changes only with DoneSig", badChange, 0);

        // 6: DONE_CYCLES=3 instance
        sendFrame(1'b1, 8'hC4, 1'b1);
        Rx3 = 1'b1;
        idle(10);
        check("t6 done3Count", done3Count, 1);
        check("t6 done3 width", done3High, 3);
        check("t6 Data captured", data3Cap, 8'hC4);
        check("t6 DoneSig low", DoneSig3, 0);
        check("t6 RxBusy low", RxBusy3, 0);
        check("t6 no FrameErr", ferr3High, 0);
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Data3 !== 8'hC4) stable = 1'b0;
        end
        check("t6 Data stable 100 clks", stable, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
